mips_front_pipe_regs: RTL and testbench
=======================================

// Module: mips_front_pipe_regs
// PURPOSE
// - Holds the three front-end pipeline registers of the 5-stage MIPS core: IF/ID, ID/EX and EX/MEM, in one block.
// - Captures fetch, decode and execute results on each rising clock edge and presents them to the next stage.
// - The EX/MEM bank chains internally from the ID/EX outputs. An instruction entering at IF reaches the MEM outputs 3 cycles later.
// PARAMETERS
// - (none; all widths fixed: 32-bit datapath, 26-bit jump field, 5-bit register numbers, 22-bit control bundle)
// PORTS
// clk            in   1   single clock, all registers update on posedge
// rst_b          in   1   asynchronous, active-low reset
// if_inst        in   32  fetched instruction
// if_halted      in   1   halt indication from fetch
// id_inst        out  32  IF/ID instruction
// id_halted      out  1   IF/ID halt bit
// id_inst_addr   in   32  PC of the decoded instruction
// id_rs_data     in   32  register-file rs read value
// id_rt_data     in   32  register-file rt read value
// id_imm         in   32  sign/zero-extended immediate
// id_jea         in   26  jump target field
// id_ctrl        in   22  decoder control bundle (layout below)
// id_is_nop      in   1   decoder bubble flag
// ex_inst, ex_inst_addr, ex_rs_data, ex_rt_data, ex_imm  out  32  ID/EX copies
// ex_jea         out  26  ID/EX copy
// ex_ctrl        out  22  ID/EX copy
// ex_is_nop      out  1   ID/EX copy
// ex_halted      out  1   ID/EX copy of id_halted
// ex_rs_num, ex_rt_num, ex_rd_num_f, ex_shamt  out  5  = ex_inst[25:21], [20:16], [15:11], [10:6] (combinational)
// ex_funct       out  6   = ex_inst[5:0] (combinational)
// ex_alu_result  in   32  ALU output
// ex_rd_num      in   5   selected destination register
// ex_zero        in   1   ALU zero flag
// mem_inst, mem_inst_addr, mem_alu_result, mem_rt_data, mem_imm  out  32  EX/MEM copies
// mem_rd_num     out  5   EX/MEM copy
// mem_ctrl       out  22  EX/MEM copy of ex_ctrl
// mem_zero, mem_is_nop, mem_halted  out  1  EX/MEM copies
// BEHAVIOUR
// - ctrl layout:
//   [1:0] dest_reg, [2] alu_src, [7:3] alu_op, [8] we_memory, [9] reg_write, [11:10] reg_src,
//   [12] branch, [13] jump, [14] jump_reg, [15] pc_enable, [16] cache_in_type, [17] we_cache,
//   [18] set_dirty, [19] set_valid, [20] mem_addr_type, [21] is_word.
// - Each bank is a plain register, latency exactly 1 cycle. No enable and no stall; every bank loads on every posedge.
// - EX/MEM sources:
//   - inst, inst_addr, rt_data, imm, ctrl, is_nop and halted come from the registered ex_* outputs.
//   - alu_result, rd_num and zero come from the ex_* inputs.
// - Reset (rst_b=0) asynchronously clears every register to 0, except ex_is_nop=1 and mem_is_nop=1 (bubble).
// - Reset takes effect immediately, including mid-cycle. The first capture is at the first posedge with rst_b=1.
// - All fields pass through unmodified; no masking of ctrl by is_nop or halted.
// - halted is not sticky; it is a plain pipelined bit.
// - Outputs are register-driven except the ex_inst slice fields; no X propagation after reset.
// CONFIGURATION
// - PIPE_FLUSH_EN defined: adds input `flush` (1 bit).
//   - When flush=1 at a posedge: IF/ID loads inst=0 and halted=0.
//   - ID/EX loads all-zero fields with is_nop=1.
//   - EX/MEM loads normally.
// - PIPE_FLUSH_EN undefined: no flush port; the block behaves as if flush=0.
// TESTING
// - Reset: rst_b=0 mid-cycle -> all outputs 0 immediately, ex_is_nop=mem_is_nop=1.
// - Pipeline timing: if_inst=32'h2008_0005 at posedge 1 -> id_inst at cycle 1.
//   With id_*=ex_* loopback, ex_inst at cycle 2, mem_inst at cycle 3, each =32'h2008_0005.
// - Field slicing: ex_inst=32'h0123_4567 -> ex_funct=6'h27, ex_rs_num=9, ex_rt_num=3, ex_rd_num_f=8, ex_shamt=21.
// - Control chaining: id_ctrl=22'h2A_5A5A, id_is_nop=0 -> ex_ctrl=22'h2A_5A5A next cycle, mem_ctrl one cycle later.
//   ex_alu_result=32'hDEAD_BEEF, ex_rd_num=31, ex_zero=1 -> mem_* equal these values after 1 cycle.
// - Halt: pulse if_halted=1 for one cycle -> id_halted, ex_halted, mem_halted each high for exactly one cycle in sequence.
// - PIPE_FLUSH_EN: flush=1 with if_inst=32'hFFFF_FFFF, id_ctrl=22'h3F_FFFF -> id_inst=0, ex_ctrl=0, ex_is_nop=1.

Source files
------------

// File: rtl/mips_front_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : mips_front_pipe_regs
// Purpose  : IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS
//            core. Optional macro PIPE_FLUSH_EN adds a `flush` input.
// Revision : 1.0 - initial release
// ============================================================================
module mips_front_pipe_regs (
   input  logic        clk,
   input  logic        rst_b,
`ifdef PIPE_FLUSH_EN
   input  logic        flush,
`endif
   // fetch side
   input  logic [31:0] if_inst,
   input  logic        if_halted,
   output logic [31:0] id_inst,
   output logic        id_halted,
   // decode side
   input  logic [31:0] id_inst_addr,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [25:0] id_jea,
   input  logic [21:0] id_ctrl,
   input  logic        id_is_nop,
   output logic [31:0] ex_inst,
   output logic [31:0] ex_inst_addr,
   output logic [31:0] ex_rs_data,
   output logic [31:0] ex_rt_data,
   output logic [31:0] ex_imm,
   output logic [25:0] ex_jea,
   output logic [21:0] ex_ctrl,
   output logic        ex_is_nop,
   output logic        ex_halted,
   output logic [4:0]  ex_rs_num,
   output logic [4:0]  ex_rt_num,
   output logic [4:0]  ex_rd_num_f,
   output logic [4:0]  ex_shamt,
   output logic [5:0]  ex_funct,
   // execute side
   input  logic [31:0] ex_alu_result,
   input  logic [4:0]  ex_rd_num,
   input  logic        ex_zero,
   output logic [31:0] mem_inst,
   output logic [31:0] mem_inst_addr,
   output logic [31:0] mem_alu_result,
   output logic [31:0] mem_rt_data,
   output logic [31:0] mem_imm,
   output logic [4:0]  mem_rd_num,
   output logic [21:0] mem_ctrl,
   output logic        mem_zero,
   output logic        mem_is_nop,
   output logic        mem_halted
);

   logic w_flush;

`ifdef PIPE_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // IF/ID bank
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         id_inst   <= '0;
         id_halted <= 1'b0;
      end else if (w_flush) begin
         id_inst   <= '0;
         id_halted <= 1'b0;
      end else begin
         id_inst   <= if_inst;
         id_halted <= if_halted;
      end
   end

   // ID/EX bank; reset and flush both leave a bubble behind
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ex_inst      <= '0;
         ex_inst_addr <= '0;
         ex_rs_data   <= '0;
         ex_rt_data   <= '0;
         ex_imm       <= '0;
         ex_jea       <= '0;
         ex_ctrl      <= '0;
         ex_is_nop    <= 1'b1;
         ex_halted    <= 1'b0;
      end else if (w_flush) begin
         ex_inst      <= '0;
         ex_inst_addr <= '0;
         ex_rs_data   <= '0;
         ex_rt_data   <= '0;
         ex_imm       <= '0;
         ex_jea       <= '0;
         ex_ctrl      <= '0;
         ex_is_nop    <= 1'b1;
         ex_halted    <= 1'b0;
      end else begin
         ex_inst      <= id_inst;
         ex_inst_addr <= id_inst_addr;
         ex_rs_data   <= id_rs_data;
         ex_rt_data   <= id_rt_data;
         ex_imm       <= id_imm;
         ex_jea       <= id_jea;
         ex_ctrl      <= id_ctrl;
         ex_is_nop    <= id_is_nop;
         ex_halted    <= id_halted;
      end
   end

   assign ex_rs_num   = ex_inst[25:21];
   assign ex_rt_num   = ex_inst[20:16];
   assign ex_rd_num_f = ex_inst[15:11];
   assign ex_shamt    = ex_inst[10:6];
   assign ex_funct    = ex_inst[5:0];

   // EX/MEM bank: mixes registered ID/EX state with live execute results
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_inst       <= '0;
         mem_inst_addr  <= '0;
         mem_alu_result <= '0;
         mem_rt_data    <= '0;
         mem_imm        <= '0;
         mem_rd_num     <= '0;
         mem_ctrl       <= '0;
         mem_zero       <= 1'b0;
         mem_is_nop     <= 1'b1;
         mem_halted     <= 1'b0;
      end else begin
         mem_inst       <= ex_inst;
         mem_inst_addr  <= ex_inst_addr;
         mem_alu_result <= ex_alu_result;
         mem_rt_data    <= ex_rt_data;
         mem_imm        <= ex_imm;
         mem_rd_num     <= ex_rd_num;
         mem_ctrl       <= ex_ctrl;
         mem_zero       <= ex_zero;
         mem_is_nop     <= ex_is_nop;
         mem_halted     <= ex_halted;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_front_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_front_pipe_regs
// Purpose  : Self-checking bench for mips_front_pipe_regs (random + directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_front_pipe_regs;

   localparam int NMAX = 256;

   logic        clk, rst_b;
   logic        flush;
   logic [31:0] if_inst;
   logic        if_halted;
   logic [31:0] id_inst;
   logic        id_halted;
   logic [31:0] id_inst_addr, id_rs_data, id_rt_data, id_imm;
   logic [25:0] id_jea;
   logic [21:0] id_ctrl;
   logic        id_is_nop;
   logic [31:0] ex_inst, ex_inst_addr, ex_rs_data, ex_rt_data, ex_imm;
   logic [25:0] ex_jea;
   logic [21:0] ex_ctrl;
   logic        ex_is_nop, ex_halted;
   logic [4:0]  ex_rs_num, ex_rt_num, ex_rd_num_f, ex_shamt;
   logic [5:0]  ex_funct;
   logic [31:0] ex_alu_result;
   logic [4:0]  ex_rd_num;
   logic        ex_zero;
   logic [31:0] mem_inst, mem_inst_addr, mem_alu_result, mem_rt_data, mem_imm;
   logic [4:0]  mem_rd_num;
   logic [21:0] mem_ctrl;
   logic        mem_zero, mem_is_nop, mem_halted;

   mips_front_pipe_regs dut (
      .clk(clk), .rst_b(rst_b),
`ifdef PIPE_FLUSH_EN
      .flush(flush),
`endif
      .if_inst(if_inst), .if_halted(if_halted),
      .id_inst(id_inst), .id_halted(id_halted),
      .id_inst_addr(id_inst_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_jea(id_jea), .id_ctrl(id_ctrl), .id_is_nop(id_is_nop),
      .ex_inst(ex_inst), .ex_inst_addr(ex_inst_addr), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_jea(ex_jea), .ex_ctrl(ex_ctrl),
      .ex_is_nop(ex_is_nop), .ex_halted(ex_halted),
      .ex_rs_num(ex_rs_num), .ex_rt_num(ex_rt_num), .ex_rd_num_f(ex_rd_num_f),
      .ex_shamt(ex_shamt), .ex_funct(ex_funct),
      .ex_alu_result(ex_alu_result), .ex_rd_num(ex_rd_num), .ex_zero(ex_zero),
      .mem_inst(mem_inst), .mem_inst_addr(mem_inst_addr), .mem_alu_result(mem_alu_result),
      .mem_rt_data(mem_rt_data), .mem_imm(mem_imm), .mem_rd_num(mem_rd_num),
      .mem_ctrl(mem_ctrl), .mem_zero(mem_zero), .mem_is_nop(mem_is_nop),
      .mem_halted(mem_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus history, indexed by posedge number since reset release (1-based)
   logic [31:0] s_if_inst [NMAX];
   logic        s_if_halt [NMAX];
   logic [31:0] s_addr [NMAX];
   logic [31:0] s_rs   [NMAX];
   logic [31:0] s_rt   [NMAX];
   logic [31:0] s_imm  [NMAX];
   logic [25:0] s_jea  [NMAX];
   logic [21:0] s_ctrl [NMAX];
   logic        s_nop  [NMAX];
   logic [31:0] s_alu  [NMAX];
   logic [4:0]  s_rd   [NMAX];
   logic        s_zero [NMAX];
   logic        s_flush[NMAX];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 1;

   // Reference: each stage value after posedge n, derived from input history.
   // Index < 1 means "no capture since reset", i.e. the reset value.
   function automatic logic [31:0] m_id_inst(int n);
      return (n < 1 || s_flush[n]) ? 32'h0 : s_if_inst[n];
   endfunction
   function automatic logic m_id_halt(int n);
      return (n < 1 || s_flush[n]) ? 1'b0 : s_if_halt[n];
   endfunction
   function automatic logic [31:0] m_ex_inst(int n);
      return (n < 1 || s_flush[n]) ? 32'h0 : m_id_inst(n - 1);
   endfunction
   function automatic logic m_ex_halt(int n);
      return (n < 1 || s_flush[n]) ? 1'b0 : m_id_halt(n - 1);
   endfunction
   function automatic logic [31:0] m_ex_w(int n, logic [31:0] v);
      return (n < 1 || s_flush[n]) ? 32'h0 : v;
   endfunction
   function automatic logic m_ex_nop(int n);
      return (n < 1 || s_flush[n]) ? 1'b1 : s_nop[n];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all(input int n);
      logic [31:0] e_ex_inst;
      int p;
      p = (n < 1) ? 0 : n - 1;
      e_ex_inst = m_ex_inst(n);
      chk("id_inst",      id_inst,               m_id_inst(n));
      chk("id_halted",    32'(id_halted),        32'(m_id_halt(n)));
      chk("ex_inst",      ex_inst,               e_ex_inst);
      chk("ex_inst_addr", ex_inst_addr,          m_ex_w(n, s_addr[n]));
      chk("ex_rs_data",   ex_rs_data,            m_ex_w(n, s_rs[n]));
      chk("ex_rt_data",   ex_rt_data,            m_ex_w(n, s_rt[n]));
      chk("ex_imm",       ex_imm,                m_ex_w(n, s_imm[n]));
      chk("ex_jea",       32'(ex_jea),           m_ex_w(n, 32'(s_jea[n])));
      chk("ex_ctrl",      32'(ex_ctrl),          m_ex_w(n, 32'(s_ctrl[n])));
      chk("ex_is_nop",    32'(ex_is_nop),        32'(m_ex_nop(n)));
      chk("ex_halted",    32'(ex_halted),        32'(m_ex_halt(n)));
      chk("ex_rs_num",    32'(ex_rs_num),        32'(e_ex_inst[25:21]));
      chk("ex_rt_num",    32'(ex_rt_num),        32'(e_ex_inst[20:16]));
      chk("ex_rd_num_f",  32'(ex_rd_num_f),      32'(e_ex_inst[15:11]));
      chk("ex_shamt",     32'(ex_shamt),         32'(e_ex_inst[10:6]));
      chk("ex_funct",     32'(ex_funct),         32'(e_ex_inst[5:0]));
      chk("mem_inst",       mem_inst,            (n < 1) ? 32'h0 : m_ex_inst(p));
      chk("mem_inst_addr",  mem_inst_addr,       (n < 1) ? 32'h0 : m_ex_w(p, s_addr[p]));
      chk("mem_rt_data",    mem_rt_data,         (n < 1) ? 32'h0 : m_ex_w(p, s_rt[p]));
      chk("mem_imm",        mem_imm,             (n < 1) ? 32'h0 : m_ex_w(p, s_imm[p]));
      chk("mem_ctrl",       32'(mem_ctrl),       (n < 1) ? 32'h0 : m_ex_w(p, 32'(s_ctrl[p])));
      chk("mem_is_nop",     32'(mem_is_nop),     (n < 1) ? 32'h1 : 32'(m_ex_nop(p)));
      chk("mem_halted",     32'(mem_halted),     (n < 1) ? 32'h0 : 32'(m_ex_halt(p)));
      chk("mem_alu_result", mem_alu_result,      (n < 1) ? 32'h0 : s_alu[n]);
      chk("mem_rd_num",     32'(mem_rd_num),     (n < 1) ? 32'h0 : 32'(s_rd[n]));
      chk("mem_zero",       32'(mem_zero),       (n < 1) ? 32'h0 : 32'(s_zero[n]));
   endtask

   task automatic rand_fill(input int n, input bit allow_flush);
      s_if_inst[n] = $urandom;
      s_if_halt[n] = 1'($urandom);
      s_addr[n]    = $urandom;
      s_rs[n]      = $urandom;
      s_rt[n]      = $urandom;
      s_imm[n]     = $urandom;
      s_jea[n]     = 26'($urandom);
      s_ctrl[n]    = 22'($urandom);
      s_nop[n]     = 1'($urandom);
      s_alu[n]     = $urandom;
      s_rd[n]      = 5'($urandom);
      s_zero[n]    = 1'($urandom);
`ifdef PIPE_FLUSH_EN
      s_flush[n]   = allow_flush && ($urandom_range(7) == 0);
`else
      s_flush[n]   = 1'b0;
      if (allow_flush) s_flush[n] = 1'b0;
`endif
   endtask

   task automatic quiet_fill(input int n);
      rand_fill(n, 1'b0);
      s_if_halt[n] = 1'b0;
   endtask

   // Drive history entry cyc, clock it in, check one time unit later
   task automatic step();
      if (cyc >= NMAX) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NMAX);
         n_err++;
         $fatal(1, "cycle budget exceeded");
      end
      if_inst = s_if_inst[cyc];  if_halted = s_if_halt[cyc];
      id_inst_addr = s_addr[cyc]; id_rs_data = s_rs[cyc]; id_rt_data = s_rt[cyc];
      id_imm = s_imm[cyc]; id_jea = s_jea[cyc]; id_ctrl = s_ctrl[cyc];
      id_is_nop = s_nop[cyc]; ex_alu_result = s_alu[cyc]; ex_rd_num = s_rd[cyc];
      ex_zero = s_zero[cyc]; flush = s_flush[cyc];
      @(posedge clk);
      #1;
      check_all(cyc);
      cyc++;
   endtask

   initial begin
      for (int i = 0; i < NMAX; i++) rand_fill(i, 1'b0);
      s_flush[0] = 1'b0;
      rst_b = 1'b0;
      if_inst = '1; if_halted = 1'b1; id_inst_addr = '1; id_rs_data = '1;
      id_rt_data = '1; id_imm = '1; id_jea = '1; id_ctrl = '1; id_is_nop = 1'b0;
      ex_alu_result = '1; ex_rd_num = '1; ex_zero = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all(0);
      #2 rst_b = 1'b1;
      cyc = 1;

      // pipeline timing: one instruction walks IF -> ID -> EX -> MEM
      quiet_fill(cyc); s_if_inst[cyc] = 32'h2008_0005; step();
      chk("timing_id", id_inst, 32'h2008_0005);
      quiet_fill(cyc); s_if_inst[cyc] = 32'h0123_4567; step();
      chk("timing_ex", ex_inst, 32'h2008_0005);
      quiet_fill(cyc); s_ctrl[cyc] = 22'h2A_5A5A; s_nop[cyc] = 1'b0; step();
      chk("timing_mem", mem_inst, 32'h2008_0005);
      chk("slice_funct", 32'(ex_funct), 32'h27);
      chk("slice_rs",    32'(ex_rs_num), 32'd9);
      chk("slice_rt",    32'(ex_rt_num), 32'd3);
      chk("slice_rd",    32'(ex_rd_num_f), 32'd8);
      chk("slice_shamt", 32'(ex_shamt), 32'd21);
      chk("ctrl_ex",     32'(ex_ctrl), 32'h2A_5A5A);
      chk("nop_ex",      32'(ex_is_nop), 32'd0);
      quiet_fill(cyc); s_alu[cyc] = 32'hDEAD_BEEF; s_rd[cyc] = 5'd31; s_zero[cyc] = 1'b1; step();
      chk("ctrl_mem",    32'(mem_ctrl), 32'h2A_5A5A);
      chk("alu_mem",     mem_alu_result, 32'hDEAD_BEEF);
      chk("rd_mem",      32'(mem_rd_num), 32'd31);
      chk("zero_mem",    32'(mem_zero), 32'd1);

      // single-cycle halt pulse travels through each bank exactly once
      quiet_fill(cyc); s_if_halt[cyc] = 1'b1; step();
      chk("halt_id", 32'(id_halted), 32'd1);
      for (int k = 0; k < 4; k++) begin
         quiet_fill(cyc); step();
         chk("halt_id_low", 32'(id_halted), 32'd0);
         chk("halt_ex",  32'(ex_halted),  (k == 0) ? 32'd1 : 32'd0);
         chk("halt_mem", 32'(mem_halted), (k == 1) ? 32'd1 : 32'd0);
      end

`ifdef PIPE_FLUSH_EN
      quiet_fill(cyc); s_if_inst[cyc] = 32'hFFFF_FFFF; s_ctrl[cyc] = 22'h3F_FFFF;
      s_nop[cyc] = 1'b0; s_flush[cyc] = 1'b1; step();
      chk("flush_id_inst", id_inst, 32'h0);
      chk("flush_ex_ctrl", 32'(ex_ctrl), 32'h0);
      chk("flush_ex_nop",  32'(ex_is_nop), 32'd1);
`endif

      // random traffic
      for (int k = 0; k < 60; k++) begin
         rand_fill(cyc, 1'b1);
         step();
      end

      // asynchronous reset asserted mid-cycle must clear outputs at once
      #3 rst_b = 1'b0;
      #1 check_all(0);
      chk("async_ex_nop",  32'(ex_is_nop),  32'd1);
      chk("async_mem_nop", 32'(mem_is_nop), 32'd1);
      #1 rst_b = 1'b1;
      cyc = 1;
      for (int k = 0; k < 40; k++) begin
         rand_fill(cyc, 1'b1);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
